hazard_unit: RTL
================

# hazard_unit

Pipeline hazard controller that drives the hold, bubble and flush inputs of the IF/ID and ID/EX pipeline buffers. It tracks in-flight register writes in a scoreboard and stalls the front end on read-after-write dependences. It also squashes wrong-path instructions when a jump or branch resolves downstream. The block sits beside the decode stage, reads decode fields plus the resolved redirect from the EX/MEM side, and has no datapath of its own.

## Interface
Parameters:
- REG_AW, 6, register-address width
- DEPTH, 3, number of in-flight write slots tracked (ID/EX, EX/MEM, MEM/WB)
- FLUSH_CYCLES, 2, cycles of squash per redirect (1..7)
- CNT_W, 16, stall-counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; synchronous, active-low
- id_valid  in  1  decode stage holds a real instruction
- id_rs1  in  REG_AW  source register 1 of the decode instruction
- id_rs2  in  REG_AW  source register 2 of the decode instruction
- id_use_rs2  in  1  rs2 is actually read
- id_rd  in  REG_AW  destination register
- id_reg_write  in  1  decode instruction writes rd
- id_mem_read  in  1  decode instruction is a load
- ex_redirect  in  1  one-cycle pulse: jump/branch taken, resolved at the EX/MEM buffer
- pc_hold  out  1  freeze the PC
- if_id_hold  out  1  IF/ID buffer keeps its contents
- if_id_flush  out  1  IF/ID buffer loads a NOP
- id_ex_bubble  out  1  ID/EX buffer loads all-zero control bits
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation
- Scoreboard: DEPTH entries of {valid, rd, is_load}. Each clock, entry[i] <= entry[i-1] for i ≥ 1.
- entry[0] loads {1, id_rd, id_mem_read} only when id_valid && id_reg_write && the instruction advances (no stall, no flush). Otherwise entry[0] loads invalid.
- hazard is asserted when id_valid is high and some tracked valid entry has rd == id_rs1, or has rd == id_rs2 with id_use_rs2 high. Register 0 is not special.
- FSM states:
  - RUN: hazard → STALL; ex_redirect → FLUSH.
  - STALL: the same hazard is re-evaluated every cycle. It returns to RUN when hazard clears. ex_redirect → FLUSH.
  - FLUSH: a counter loads FLUSH_CYCLES-1 on entry. Return to RUN when the counter reaches 0. A further ex_redirect reloads the counter.
- Outputs are combinational from the state, the scoreboard and the current inputs.
  - Stall (hazard and not flushing): pc_hold=1, if_id_hold=1, id_ex_bubble=1.
  - Flush (ex_redirect, or state FLUSH): if_id_flush=1, id_ex_bubble=1, pc_hold=0, if_id_hold=0.
- Redirect has priority over stall in the same cycle.
- On ex_redirect, entry[0] is invalidated because it belongs to a younger, squashed instruction. Older entries are kept.
- stall_count increments on each stall cycle (flush cycles are not counted). It saturates at all-ones.

## Timing
- Reset (rst_n low at a clk edge): state RUN, all entries invalid, counter 0, stall_count 0. All control outputs are 0 in the reset cycle and afterwards until an event occurs. Reset mid-stall or mid-flush abandons it immediately.
- Stall and flush outputs act in the same cycle as their cause (zero latency). Scoreboard and state update at the next edge.
- Without HAZARD_FWD_EN, a consumer directly behind its producer stalls DEPTH cycles (3 by default). At distance 2 it stalls DEPTH-1 cycles. At distance > DEPTH it does not stall.
- Redirect squashes exactly FLUSH_CYCLES cycles, counting the pulse cycle.
- A redirect in the last flush cycle extends the flush by a full FLUSH_CYCLES.

## Configuration
- HAZARD_FWD_EN defined: a forwarding network exists, so hazard considers only entry[0] and only when is_load is set. A load-use pair stalls exactly 1 cycle, and ALU-to-ALU dependences never stall.
- HAZARD_FWD_EN undefined: all DEPTH entries are compared regardless of is_load, as described above.

## Structure
- The shared package (pipeline_pkg) holds the FSM state typedef (RUN/STALL/FLUSH), the scoreboard entry struct, and the REG_AW/DEPTH defaults.
- One sub-module, hazard_scoreboard, contains the shift register and the comparators and exports hazard. The FSM, the flush counter and stall_count stay in hazard_unit.

## Test plan
- Reset: rst_n=0 for 2 cycles with ex_redirect=1 → all outputs 0, stall_count=0 after release.
- No forwarding: write r5 then immediately read r5 → pc_hold/if_id_hold/id_ex_bubble high for 3 cycles, stall_count=3. Reading r5 four instructions later → no stall.
- HAZARD_FWD_EN: load r7 then add using r7 → 1 stall cycle. ALU write r7 then read r7 → 0 stall cycles.
- Redirect: ex_redirect pulse → if_id_flush and id_ex_bubble high for 2 cycles. A second pulse in the 2nd cycle → 3 flush cycles total.
- Redirect during a stall: ex_redirect while hazard is active → flush wins, pc_hold=0 that cycle, entry[0] cleared, and the stall does not resume.
- Saturation: CNT_W=4, hold a hazard for 20 cycles → stall_count stops at 15.

Source files
------------

// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
//   Shared types and defaults for the pipeline hazard controller.
//   - hz_state_e : hazard FSM states (RUN / STALL / FLUSH)
//   - sb_entry_t : one scoreboard slot {valid, is_load, rd}
//   - REG_AW_DEF / DEPTH_DEF : default register-address width and slot count
//   The scoreboard rd field is sized to RD_MAX_W so the struct can be shared
//   by any instance with REG_AW <= RD_MAX_W; narrower addresses are
//   zero-extended before storage and comparison.
// ---------------------------------------------------------------------------
package pipeline_pkg;

    localparam int REG_AW_DEF = 6;
    localparam int DEPTH_DEF  = 3;
    localparam int RD_MAX_W   = 8;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic                valid;
        logic                is_load;
        logic [RD_MAX_W-1:0] rd;
    } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//   Shift register of in-flight register writes plus the RAW comparators.
//   Slot 0 mirrors the ID/EX buffer, slot 1 EX/MEM, slot 2 MEM/WB.
//   Configuration macro: HAZARD_FWD_EN
//     defined   : forwarding exists, only a load sitting in slot 0 can cause
//                 a hazard (load-use).
//     undefined : every valid slot is compared against the decode sources.
//
//   Ports
//     clk, rst_n      clock, synchronous active-low reset
//     id_valid        decode holds a real instruction
//     id_rs1, id_rs2  decode source registers; id_use_rs2 qualifies rs2
//     id_rd           decode destination; id_reg_write qualifies it
//     id_mem_read     decode instruction is a load
//     advance         decode instruction moves into ID/EX this cycle
//     squash          redirect: the instruction now in ID/EX is wrong-path
//     hazard          RAW dependence against a tracked write (combinational)
// ---------------------------------------------------------------------------
module hazard_scoreboard
    import pipeline_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              advance,
    input  logic              squash,
    output logic              hazard
);

    sb_entry_t sb_q [DEPTH];
    sb_entry_t sb_d [DEPTH];

    logic [RD_MAX_W-1:0] rs1_x;
    logic [RD_MAX_W-1:0] rs2_x;
    logic                sb_unused;

    assign rs1_x = RD_MAX_W'(id_rs1);
    assign rs2_x = RD_MAX_W'(id_rs2);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            sb_d[i] = '0;
        end
        if (id_valid && id_reg_write && advance) begin
            sb_d[0].valid   = 1'b1;
            sb_d[0].is_load = id_mem_read;
            sb_d[0].rd      = RD_MAX_W'(id_rd);
        end
        // On a redirect the current slot-0 instruction is younger than the
        // branch, so it is dropped instead of moving on to slot 1.
        for (int i = 1; i < DEPTH; i++) begin
            sb_d[i] = (i == 1 && squash) ? '0 : sb_q[i-1];
        end
    end

    always_comb begin
        hazard = 1'b0;
`ifdef HAZARD_FWD_EN
        if (id_valid && sb_q[0].valid && sb_q[0].is_load &&
            ((sb_q[0].rd == rs1_x) || (id_use_rs2 && (sb_q[0].rd == rs2_x)))) begin
            hazard = 1'b1;
        end
`else
        for (int i = 0; i < DEPTH; i++) begin
            if (id_valid && sb_q[i].valid &&
                ((sb_q[i].rd == rs1_x) || (id_use_rs2 && (sb_q[i].rd == rs2_x)))) begin
                hazard = 1'b1;
            end
        end
`endif
    end

    // Not every field is read in every configuration (is_load without
    // forwarding, older slots with forwarding); fold them into a sink.
    always_comb begin
        sb_unused = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            sb_unused = sb_unused ^ (^sb_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                sb_q[i] <= '0;
            end
        end else begin
            sb_q <= sb_d;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
//   Drives hold / bubble / flush of the IF/ID and ID/EX buffers. Stalls the
//   front end on read-after-write dependences tracked by hazard_scoreboard
//   and squashes wrong-path instructions for FLUSH_CYCLES cycles after a
//   resolved jump/branch (ex_redirect). Redirect outranks stall.
//   Configuration macro: HAZARD_FWD_EN (see hazard_scoreboard).
//
//   Ports
//     clk, rst_n         clock, synchronous active-low reset
//     id_*               decode-stage instruction fields
//     ex_redirect        one-cycle taken jump/branch pulse from EX/MEM
//     pc_hold            freeze the PC
//     if_id_hold         IF/ID keeps its contents
//     if_id_flush        IF/ID loads a NOP
//     id_ex_bubble       ID/EX loads zero control bits
//     stall_count        saturating count of stall cycles
//   All control outputs are combinational and forced low while rst_n is low.
// ---------------------------------------------------------------------------
module hazard_unit
    import pipeline_pkg::*;
#(
    parameter int REG_AW       = REG_AW_DEF,
    parameter int DEPTH        = DEPTH_DEF,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              ex_redirect,
    output logic              pc_hold,
    output logic              if_id_hold,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic [CNT_W-1:0]  stall_count
);

    // Counter holds the flush cycles still to come after the current one.
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    hz_state_e        state_q, state_d;
    logic [2:0]       fcnt_q, fcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic hazard;
    logic flushing;
    logic stalling;
    logic advance;

    assign flushing = ex_redirect || (state_q == ST_FLUSH);
    assign stalling = hazard && !flushing;
    assign advance  = !stalling && !flushing;

    hazard_scoreboard #(
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .advance      (advance),
        .squash       (ex_redirect),
        .hazard       (hazard)
    );

    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        stall_cnt_d = stall_cnt_q;

        if (stalling && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end

        if (ex_redirect) begin
            // The pulse cycle is the first flush cycle; a single-cycle
            // flush never needs the FLUSH state.
            fcnt_d  = FLUSH_RELOAD;
            state_d = (FLUSH_RELOAD != 3'd0) ? ST_FLUSH : ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (hazard) begin
                        state_d = ST_STALL;
                    end
                end
                ST_STALL: begin
                    if (!hazard) begin
                        state_d = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if (fcnt_q <= 3'd1) begin
                        state_d = ST_RUN;
                        fcnt_d  = 3'd0;
                    end else begin
                        fcnt_d = fcnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    fcnt_d  = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            fcnt_q      <= 3'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pc_hold      = rst_n && stalling;
    assign if_id_hold   = rst_n && stalling;
    assign if_id_flush  = rst_n && flushing;
    assign id_ex_bubble = rst_n && (stalling || flushing);
    assign stall_count  = stall_cnt_q;

endmodule
